cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Backing-memory responder for the direct-mapped L1 cache. It serves 20-bit block reads (allocation) and block writes (write-back) issued by the cache's memory port, with a programmable fixed access latency and a one-cycle `mem_ready` completion pulse. It sits between the cache's `mem_*` outputs and the test/SoC top, and replaces the ad-hoc RAM model with a deterministic, latency-accurate responder.

## Interface
- `LATENCY`, default 3: cycles from request acceptance to the `mem_ready` pulse; legal range 1..15.
- `clk  in  1`: clock; all state changes on rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `mem_req  in  1`: request valid; requester holds it high with stable `mem_rw`/`mem_addr`/`mem_wdata` until `mem_ready`.
- `mem_rw  in  1`: 0 = block read, 1 = block write.
- `mem_addr  in  10`: word address; block index = `mem_addr[9:1]`, `mem_addr[0]` ignored.
- `mem_wdata  in  20`: write block; `[9:0]` = even word, `[19:10]` = odd word.
- `mem_rdata  out  20`: read block, registered, same half ordering as `mem_wdata`.
- `mem_ready  out  1`: one-cycle completion pulse for the accepted request.
- `busy  out  1`: high from acceptance through the `mem_ready` cycle.

## Operation
- Storage: 512 x 20-bit blocks. Not cleared by reset. Time-zero contents: word address a holds a, i.e. block n = {10'(2n+1), 10'(2n)}.
- States: IDLE, WAIT, DONE.
- IDLE: on an edge with `mem_req`=1, latch block index, `mem_rw` and `mem_wdata`; load counter with LATENCY-1.
  - LATENCY=1: go directly to DONE.
  - Otherwise: go to WAIT.
- WAIT: decrement counter each edge. Inputs are ignored; the latched values are used. On the edge where counter is 1, go to DONE.
- Entry into DONE (same edge) performs the access:
  - Write: mem[idx] <= latched wdata.
  - Read: `mem_rdata` <= mem[idx].
- DONE: `mem_ready`=1 for exactly this cycle. Next edge goes to IDLE unconditionally; `mem_req` is not sampled in DONE.
- Back-to-back: a request still high in the first IDLE cycle after DONE is accepted as a new request. The requester must drop `mem_req` in the DONE cycle to avoid a duplicate.
- `mem_rdata` holds its value until the next read completes. Writes never change it.
- Read-after-write to the same block returns the written data.

## Timing
- Reset values: state IDLE, `mem_ready`=0, `busy`=0, `mem_rdata`=0, counter=0.
- Reset asserted mid-request: aborts with no memory write and no `mem_ready` pulse.
- Acceptance edge = E0. Completion:
  - `mem_ready` high during the cycle after edge E0+LATENCY-1.
  - Equivalently, visible LATENCY cycles after `mem_req` is first sampled.
  - Read data valid in the same cycle as `mem_ready`.
- Write commit visible to a read accepted at or after the DONE cycle.
- `busy` asserts the cycle after E0 and deasserts the cycle after `mem_ready`.
- `mem_ready` and `busy` are registered (state-decoded). They are never combinational from inputs.
- Minimum request period: LATENCY+1 cycles.
- `mem_addr[0]` toggling during WAIT: no effect. All other input changes during WAIT/DONE: no effect.

## Test plan
- Read, LATENCY=3: `mem_req`=1, `mem_rw`=0, `mem_addr`=50 at E0 -> `mem_ready` pulses 1 cycle in the cycle after E0+2; `mem_rdata`=`{10'd51,10'd50}`; `busy` high 3 cycles.
- Write then read: write `mem_addr`=84, `mem_wdata`=`{10'd85,10'd300}` -> `mem_ready` pulse, `mem_rdata` unchanged. Then read `mem_addr`=85 -> `{10'd85,10'd300}`.
- Input change while busy: after acceptance of a read at 67, switch `mem_addr` to 150 and `mem_rw` to 1 during WAIT -> returns `{10'd67,10'd66}`; block 75 unchanged.
- Back-to-back: hold `mem_req` high through DONE -> second identical request accepted in the following IDLE cycle; second `mem_ready` arrives LATENCY+1 cycles after the first.
- Reset mid-write: assert `rst` one cycle after accepting a write of `{10'd777,10'd777}` to address 70 -> no `mem_ready`; `busy`=0 immediately. A later read of 70 returns `{10'd71,10'd70}`.
- LATENCY=1 build: read 0 -> `mem_ready` in the cycle right after acceptance, `mem_rdata`=`{10'd1,10'd0}`; requests repeat every 2 cycles.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Fixed-latency backing-memory responder for the L1 cache memory port.
// Serves 20-bit block reads/writes and completes each with a one-cycle mem_ready pulse.
module cache_mem_responder #(
   parameter int unsigned LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic        mem_rw,
   input  logic [9:0]  mem_addr,
   input  logic [19:0] mem_wdata,
   output logic [19:0] mem_rdata,
   output logic        mem_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic [8:0]  idx;
   logic        rw;
   logic [19:0] wdata;
   logic        accept;
   logic        access;
   logic [8:0]  acc_idx;
   logic        acc_rw;
   logic [19:0] acc_wdata;

   // Storage keeps each block as the XOR against its power-up pattern (word a holds a),
   // so an all-zero array represents the required time-zero contents.
   logic [19:0] mem_delta [0:511];

   // Power-up contents of block n: {odd word 2n+1, even word 2n}.
   function automatic logic [19:0] home_block(input logic [8:0] n);
      logic [9:0] even;
      even = {n, 1'b0};
      return {even | 10'd1, even};
   endfunction

   // Next-state, counter and access-strobe decode.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req) begin
               accept  = 1'b1;
               cnt_nxt = LAT_M1;
               if (LATENCY == 1) begin
                  state_nxt = DONE;
                  access    = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               state_nxt = DONE;
               cnt_nxt   = 4'd0;
               access    = 1'b1;
            end else begin
               cnt_nxt   = cnt - 4'd1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // With LATENCY=1 the access happens on the acceptance edge, before anything is latched.
   always_comb begin
      if (state == IDLE) begin
         acc_idx   = mem_addr[9:1];
         acc_rw    = mem_rw;
         acc_wdata = mem_wdata;
      end else begin
         acc_idx   = idx;
         acc_rw    = rw;
         acc_wdata = wdata;
      end
   end

   // Control state, request latches and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         idx       <= 9'd0;
         rw        <= 1'b0;
         wdata     <= 20'd0;
         mem_rdata <= 20'd0;
         mem_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         mem_ready <= (state_nxt == DONE);
         busy      <= (state_nxt != IDLE);
         if (accept) begin
            idx   <= mem_addr[9:1];
            rw    <= mem_rw;
            wdata <= mem_wdata;
         end
         if (access && !acc_rw) begin
            mem_rdata <= mem_delta[acc_idx] ^ home_block(acc_idx);
         end
      end
   end

   // Block write port; reset blocks the commit so an aborted write leaves memory intact.
   always_ff @(posedge clk) begin
      if (access && acc_rw && !rst) begin
         mem_delta[acc_idx] <= acc_wdata ^ home_block(acc_idx);
      end
   end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench for cache_mem_responder at LATENCY=3 and LATENCY=1.
module tb_cache_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_rw, a_ready, a_busy;
   logic [9:0]  a_addr;
   logic [19:0] a_wdata, a_rdata;
   logic        b_req, b_rw, b_ready, b_busy;
   logic [9:0]  b_addr;
   logic [19:0] b_wdata, b_rdata;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   cache_mem_responder #(.LATENCY(3)) dut_l3 (
      .clk(clk), .rst(rst), .mem_req(a_req), .mem_rw(a_rw), .mem_addr(a_addr),
      .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready), .busy(a_busy)
   );

   cache_mem_responder #(.LATENCY(1)) dut_l1 (
      .clk(clk), .rst(rst), .mem_req(b_req), .mem_rw(b_rw), .mem_addr(b_addr),
      .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready), .busy(b_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic r, input logic w,
                        input logic [9:0] ad, input logic [19:0] wd);
      if (sel == 0) begin
         a_req = r; a_rw = w; a_addr = ad; a_wdata = wd;
      end else begin
         b_req = r; b_rw = w; b_addr = ad; b_wdata = wd;
      end
   endtask

   function automatic logic get_ready(input int sel);
      return (sel == 0) ? a_ready : b_ready;
   endfunction

   function automatic logic get_busy(input int sel);
      return (sel == 0) ? a_busy : b_busy;
   endfunction

   function automatic logic [19:0] get_rdata(input int sel);
      return (sel == 0) ? a_rdata : b_rdata;
   endfunction

   // One request: counts cycles to mem_ready and busy cycles; optionally scrambles inputs during WAIT.
   task automatic transact(input int sel, input string tag, input logic w, input logic [9:0] ad,
                           input logic [19:0] wd, input int exp_lat, input logic [19:0] exp_rd,
                           input bit perturb);
      int n = 0;
      int nb = 0;
      bit seen = 1'b0;
      drive(sel, 1'b1, w, ad, wd);
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (get_busy(sel)) nb++;
         if (get_ready(sel)) seen = 1'b1;
         if (perturb && n == 1) drive(sel, 1'b1, 1'b1, 10'd150, 20'hABCDE);
      end
      drive(sel, 1'b0, 1'b0, 10'd0, 20'd0);
      check({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_lat));
      check({tag, "_rdata"}, 32'(get_rdata(sel)), 32'(exp_rd));
      @(negedge clk);
      check({tag, "_ready_drop"}, 32'(get_ready(sel)), 32'd0);
      check({tag, "_busy_drop"}, 32'(get_busy(sel)), 32'd0);
   endtask

   // Request held high through DONE: measures spacing of the two completions.
   task automatic b2b(input int sel, input string tag, input logic [9:0] ad,
                      input int exp_gap, input logic [19:0] exp_rd);
      int n = 0;
      int first = -1;
      int second = -1;
      int extra = 0;
      drive(sel, 1'b1, 1'b0, ad, 20'd0);
      while (second < 0 && n < 40) begin
         @(negedge clk);
         n++;
         if (get_ready(sel)) begin
            if (first < 0) first = n;
            else second = n;
         end
      end
      drive(sel, 1'b0, 1'b0, 10'd0, 20'd0);
      check({tag, "_gap"}, 32'(second - first), 32'(exp_gap));
      check({tag, "_rdata"}, 32'(get_rdata(sel)), 32'(exp_rd));
      repeat (6) begin
         @(negedge clk);
         if (get_ready(sel)) extra++;
      end
      check({tag, "_no_extra"}, 32'(extra), 32'd0);
   endtask

   initial begin
      int nr;
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 10'd0, 20'd0);
      drive(1, 1'b0, 1'b0, 10'd0, 20'd0);
      repeat (2) @(negedge clk);
      check("reset_ready", 32'(a_ready), 32'd0);
      check("reset_busy", 32'(a_busy), 32'd0);
      check("reset_rdata", 32'(a_rdata), 32'd0);
      check("reset_rdata_l1", 32'(b_rdata), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      transact(0, "rd50", 1'b0, 10'd50, 20'd0, 3, {10'd51, 10'd50}, 1'b0);
      transact(0, "wr84", 1'b1, 10'd84, {10'd85, 10'd300}, 3, {10'd51, 10'd50}, 1'b0);
      transact(0, "rd85", 1'b0, 10'd85, 20'd0, 3, {10'd85, 10'd300}, 1'b0);
      transact(0, "rd67_scrambled", 1'b0, 10'd67, 20'd0, 3, {10'd67, 10'd66}, 1'b1);
      transact(0, "rd150", 1'b0, 10'd150, 20'd0, 3, {10'd151, 10'd150}, 1'b0);
      b2b(0, "b2b_l3", 10'd50, 4, {10'd51, 10'd50});

      // Reset one cycle after a write is accepted.
      drive(0, 1'b1, 1'b1, 10'd70, {10'd777, 10'd777});
      @(negedge clk);
      check("rstw_busy_before", 32'(a_busy), 32'd1);
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 10'd0, 20'd0);
      #1;
      check("rstw_busy_now", 32'(a_busy), 32'd0);
      check("rstw_ready_now", 32'(a_ready), 32'd0);
      nr = 0;
      repeat (5) begin
         @(negedge clk);
         if (a_ready) nr++;
      end
      check("rstw_no_ready", 32'(nr), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      transact(0, "rd70_after_abort", 1'b0, 10'd70, 20'd0, 3, {10'd71, 10'd70}, 1'b0);

      transact(1, "l1_rd0", 1'b0, 10'd0, 20'd0, 1, {10'd1, 10'd0}, 1'b0);
      transact(1, "l1_wr511", 1'b1, 10'd511, {10'd7, 10'd9}, 1, {10'd1, 10'd0}, 1'b0);
      transact(1, "l1_rd510", 1'b0, 10'd510, 20'd0, 1, {10'd7, 10'd9}, 1'b0);
      b2b(1, "b2b_l1", 10'd0, 2, {10'd1, 10'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
